t5_hsch: RTL and testbench
==========================

Name: t5_hsch

Overview:
- Hart scheduler for the four-hart barrel front end.
- Holds one word-aligned fetch PC per hart and a run mask.
- Each enabled cycle it picks the next running hart round-robin and issues that hart's fetch address.
- It applies branch redirects from execute to the owning hart's PC; it sits between execute/control and the instruction fetch port.

Parameters:
- XLEN, 32, datapath width. PCs are word addresses [XLEN-1:2].
- RSTV, 0 (XLEN-2 bits), word-address reset PC loaded into every hart.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  pipeline advance enable; all state holds when low
- bra  in  1  branch/jump taken this cycle
- bhart  in  2  hart that owns the resolving branch
- alu  in  XLEN-2  branch target word address [XLEN-1:2]
- run_set  in  4  per-hart start request, one-hot or multi-hot
- run_clr  in  4  per-hart halt request
- iadr  out  XLEN-2  fetch word address [XLEN-1:2], registered
- hart  out  2  hart id of the current fetch, registered
- ivld  out  1  current iadr/hart is a valid issue
- pc  out  XLEN  {iadr, hart}, the tagged PC passed down the pipe
- npc  out  XLEN-2  iadr+1, sequential next word address of the current fetch
- active  out  4  current run mask

Behaviour:
Reset (rst=1 at a clk edge, overrides ena and every other input):
- pcr[0..3] <= RSTV
- active <= 4'b0001 (hart 0 only)
- rr pointer <= 2'd3, so hart 0 is picked first
- iadr <= 0, hart <= 0, ivld <= 0

Per cycle with ena=1 (no state changes when ena=0; a branch presented with ena=0 is ignored):
1. Run mask update: active <= (active & ~run_clr) | run_set. Set wins over clear for the same bit. The new mask takes effect from the next selection.
2. Selection uses the current active mask. It takes the first hart with an active bit, searching rr+1, rr+2, rr+3, rr (mod 4). A single running hart is therefore selected every cycle.
3. If a hart sel is found:
   - iadr <= pcr[sel], hart <= sel, ivld <= 1, rr <= sel
   - pcr[sel] <= pcr[sel] + 1, wrapping modulo 2^(XLEN-2)
4. If no hart is active: ivld <= 0; iadr, hart and rr hold; no pcr changes.
5. Branch: if bra=1, pcr[bhart] <= alu.
   - The branch has priority over the increment when bhart == sel.
   - The branch applies even if bhart is not active, so a parked hart can be redirected before wake.

Further rules:
- Fetch latency: a PC value reaches iadr one enabled edge after its hart is selected.
- A branch target is visible on iadr at the next selection of bhart, never earlier.
- pc and npc are combinational from the iadr/hart registers. npc wraps to 0 from all-ones.
- Halting the currently issued hart does not cancel its in-flight fetch: ivld stays 1 for that cycle.
- Reset asserted mid-stream clears everything in one cycle. ivld is 0 on the first cycle after reset.

Test Plan:
1. Reset, RSTV=0x100, ena=1 for 3 cycles, only hart 0 active -> iadr = 0x100, 0x101, 0x102; hart=0, ivld=1 each cycle; pc = 0x400, 0x404, 0x408.
2. run_set=4'b1110 for one cycle after reset, then 8 enabled cycles -> hart sequence 0,1,2,3,0,1,2,3. iadr per hart increments by 1 every 4 cycles (0x100, 0x100, 0x100, 0x100, 0x101, ...).
3. All four harts running, bra=1, bhart=2, alu=0x2000 while hart 2 is being issued -> next hart-2 issue shows iadr=0x2000, then 0x2001. Other harts are unaffected.
4. run_clr=4'b0001 and run_set=4'b0001 in the same cycle -> active bit 0 stays 1. Then run_clr=4'b1111 -> ivld=0 from the following cycle, iadr holds its last value.
5. ena=0 for 5 cycles with bra=1 asserted -> iadr, hart, ivld, active and all pcr are unchanged. The branch is not taken after ena returns.
6. pcr[0] at all-ones, hart 0 issued -> iadr=all-ones, npc=0. The next hart-0 issue shows iadr=0. Asserting rst mid-sequence -> ivld=0, active=4'b0001, and hart 0 restarts at RSTV.

Source files
------------

// File: rtl/t5_hsch.sv
// t5_hsch: hart scheduler for the four-hart barrel front end.
// Keeps one word-aligned fetch PC per hart and a run mask. On each enabled
// cycle it picks the next running hart round-robin and registers that hart's
// fetch address. Branch redirects from execute overwrite the owning hart's PC.
//
// Issue semantics (valid-only, no back-pressure): ivld qualifies iadr/hart/pc/npc
// for exactly one enabled cycle. The consumer must accept every valid issue,
// and it stalls the scheduler only by dropping ena. While ena is low every
// output and every piece of internal state holds.
module t5_hsch #(
  parameter int               XLEN = 32,
  parameter logic [XLEN-3:0]  RSTV = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            bra,
  input  logic [1:0]      bhart,
  input  logic [XLEN-3:0] alu,
  input  logic [3:0]      run_set,
  input  logic [3:0]      run_clr,
  output logic [XLEN-3:0] iadr,
  output logic [1:0]      hart,
  output logic            ivld,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-3:0] npc,
  output logic [3:0]      active
);

  localparam int AW = XLEN - 2;

  // Per-hart word-address PCs and the scheduling state.
  logic [AW-1:0] r_pcr [4];
  logic [3:0]    r_active;
  logic [1:0]    r_rr;
  logic [AW-1:0] r_iadr;
  logic [1:0]    r_hart;
  logic          r_ivld;

  // Selection results.
  logic [1:0]    w_cand;
  logic [1:0]    w_sel;
  logic          w_found;

  // Round-robin pick: first active hart searching rr+1, rr+2, rr+3, rr.
  // The last issued hart is searched last, so a lone running hart is
  // picked every cycle.
  always_comb begin
    w_cand  = r_rr;
    w_sel   = r_rr;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_rr + 2'(k);
      if (!w_found && r_active[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Scheduler state: reset, run mask update, issue, PC increment and redirect.
  // The redirect is written after the increment so it wins when both hit
  // the same hart. Redirects to parked harts are applied as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < 4; h++) begin
        r_pcr[h] <= RSTV;
      end
      r_active <= 4'b0001;
      r_rr     <= 2'd3;
      r_iadr   <= '0;
      r_hart   <= 2'd0;
      r_ivld   <= 1'b0;
    end else if (ena) begin
      r_active <= (r_active & ~run_clr) | run_set;
      if (w_found) begin
        r_iadr       <= r_pcr[w_sel];
        r_hart       <= w_sel;
        r_ivld       <= 1'b1;
        r_rr         <= w_sel;
        r_pcr[w_sel] <= r_pcr[w_sel] + AW'(1);
      end else begin
        r_ivld <= 1'b0;
      end
      if (bra) begin
        r_pcr[bhart] <= alu;
      end
    end
  end

  // Fetch-side outputs; pc tags the word address with the hart id.
  assign iadr   = r_iadr;
  assign hart   = r_hart;
  assign ivld   = r_ivld;
  assign active = r_active;
  assign pc     = {r_iadr, r_hart};
  assign npc    = r_iadr + AW'(1);

endmodule

// File: tb/tb_t5_hsch.sv
// tb_t5_hsch: self-checking bench for the t5_hsch hart scheduler.
// A behavioural model tracks the four hart PCs, the run mask and the last
// issued hart; every cycle's outputs are compared against it, plus fixed
// values taken straight from the scenario descriptions.
module tb_t5_hsch;

  localparam int          XLEN = 32;
  localparam int          AW   = XLEN - 2;
  localparam logic [AW-1:0] RSTV = 30'h100;

  logic            clk;
  logic            rst;
  logic            ena;
  logic            bra;
  logic [1:0]      bhart;
  logic [AW-1:0]   alu;
  logic [3:0]      run_set;
  logic [3:0]      run_clr;
  logic [AW-1:0]   iadr;
  logic [1:0]      hart;
  logic            ivld;
  logic [XLEN-1:0] pc;
  logic [AW-1:0]   npc;
  logic [3:0]      active;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [AW-1:0] m_pc [4];
  logic [3:0]    m_act;
  int            m_last;
  logic [AW-1:0] m_iadr;
  logic [1:0]    m_hart;
  logic          m_ivld;

  t5_hsch #(.XLEN(XLEN), .RSTV(RSTV)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bra(bra), .bhart(bhart), .alu(alu),
    .run_set(run_set), .run_clr(run_clr), .iadr(iadr), .hart(hart),
    .ivld(ivld), .pc(pc), .npc(npc), .active(active)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one clock edge of scheduler behaviour, from the rules directly.
  task automatic model_step();
    int sel;
    if (rst) begin
      for (int h = 0; h < 4; h++) m_pc[h] = RSTV;
      m_act = 4'b0001; m_last = 3;
      m_iadr = '0; m_hart = 2'd0; m_ivld = 1'b0;
    end else if (ena) begin
      sel = -1;
      for (int k = 1; k <= 4; k++)
        if (sel < 0 && m_act[(m_last + k) % 4]) sel = (m_last + k) % 4;
      if (sel >= 0) begin
        m_iadr = m_pc[sel]; m_hart = 2'(sel); m_ivld = 1'b1; m_last = sel;
        m_pc[sel] = m_pc[sel] + 1;
      end else begin
        m_ivld = 1'b0;
      end
      if (bra) m_pc[bhart] = alu;
      m_act = (m_act & ~run_clr) | run_set;
    end
  endtask

  // Driver: apply inputs at negedge, let one edge pass, return at next negedge.
  task automatic cyc(input logic r, input logic e, input logic b,
                     input logic [1:0] bh, input logic [AW-1:0] a,
                     input logic [3:0] s, input logic [3:0] c);
    rst = r; ena = e; bra = b; bhart = bh; alu = a; run_set = s; run_clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (ivld !== 1'b0 || active !== 4'b0001 || iadr !== '0 || hart !== 2'd0 || pc !== '0) begin
      errors++;
      $display("FAIL reset: ivld=%b active=%b iadr=%h hart=%0d pc=%h want 0 0001 0 0 0",
               ivld, active, iadr, hart, pc);
    end
  endtask

  task automatic test_single_hart();
    cyc(1, 0, 0, 0, '0, 4'b0, 4'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
      checks++;
      if (iadr !== RSTV + AW'(i) || hart !== 2'd0 || ivld !== 1'b1 ||
          pc !== (32'h400 + 32'(4 * i)) || npc !== iadr + AW'(1)) begin
        errors++;
        $display("FAIL single_hart[%0d]: iadr=%h hart=%0d ivld=%b pc=%h npc=%h want iadr=%h pc=%h",
                 i, iadr, hart, ivld, pc, npc, RSTV + AW'(i), 32'h400 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_round_robin();
    cyc(1, 0, 0, 0, '0, 4'b0, 4'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, '0, (i == 0) ? 4'b1110 : 4'b0000, 4'b0);
      checks++;
      if (hart !== 2'(i % 4) || iadr !== RSTV + AW'(i / 4) || ivld !== 1'b1 ||
          iadr !== m_iadr || active !== m_act) begin
        errors++;
        $display("FAIL round_robin[%0d]: hart=%0d iadr=%h ivld=%b act=%b want hart=%0d iadr=%h act=%b",
                 i, hart, iadr, ivld, active, i % 4, RSTV + AW'(i / 4), m_act);
      end
    end
  endtask

  task automatic test_branch();
    logic [AW-1:0] h2 [$];
    // Harts 0 and 1 issue, then redirect hart 2 while it is being issued.
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    cyc(0, 1, 1, 2'd2, 30'h2000, 4'b0, 4'b0);
    checks++;
    if (hart !== 2'd2 || iadr !== 30'h102) begin
      errors++;
      $display("FAIL branch_same_cycle: hart=%0d iadr=%h want hart=2 iadr=102", hart, iadr);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
      if (hart == 2'd2) h2.push_back(iadr);
      checks++;
      if (iadr !== m_iadr || hart !== m_hart || ivld !== m_ivld) begin
        errors++;
        $display("FAIL branch_model[%0d]: iadr=%h hart=%0d ivld=%b want iadr=%h hart=%0d ivld=%b",
                 i, iadr, hart, ivld, m_iadr, m_hart, m_ivld);
      end
    end
    checks++;
    if (h2.size() != 2 || h2[0] !== 30'h2000 || h2[1] !== 30'h2001) begin
      errors++;
      $display("FAIL branch_target: issues=%0d first=%h second=%h want 2 2000 2001",
               h2.size(), (h2.size() > 0) ? h2[0] : '0, (h2.size() > 1) ? h2[1] : '0);
    end
  endtask

  task automatic test_set_clr();
    logic [AW-1:0] last;
    cyc(0, 1, 0, 0, '0, 4'b0001, 4'b0001);
    checks++;
    if (active !== 4'b1111) begin
      errors++;
      $display("FAIL set_wins: active=%b want 1111", active);
    end
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b1111);
    last = iadr;
    checks++;
    if (ivld !== 1'b1 || active !== 4'b0000 || iadr !== m_iadr) begin
      errors++;
      $display("FAIL halt_inflight: ivld=%b active=%b iadr=%h want 1 0000 %h", ivld, active, iadr, m_iadr);
    end
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (ivld !== 1'b0 || iadr !== last || hart !== m_hart) begin
      errors++;
      $display("FAIL halt_idle: ivld=%b iadr=%h hart=%0d want 0 %h %0d", ivld, iadr, hart, last, m_hart);
    end
  endtask

  task automatic test_ena_hold();
    logic [AW-1:0] s_iadr;
    logic [1:0]    s_hart;
    logic          s_ivld;
    logic [3:0]    s_act;
    cyc(0, 1, 0, 0, '0, 4'b1111, 4'b0);
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    s_iadr = iadr; s_hart = hart; s_ivld = ivld; s_act = active;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 2'($urandom_range(0, 3)), 30'h3000 + AW'(i), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));
      checks++;
      if (iadr !== s_iadr || hart !== s_hart || ivld !== s_ivld || active !== s_act) begin
        errors++;
        $display("FAIL ena_hold[%0d]: iadr=%h hart=%0d ivld=%b act=%b want %h %0d %b %b",
                 i, iadr, hart, ivld, active, s_iadr, s_hart, s_ivld, s_act);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
      checks++;
      if (iadr !== m_iadr || hart !== m_hart || ivld !== m_ivld || iadr[AW-1:12] == 18'h3) begin
        errors++;
        $display("FAIL ena_resume[%0d]: iadr=%h hart=%0d ivld=%b want iadr=%h hart=%0d ivld=%b",
                 i, iadr, hart, ivld, m_iadr, m_hart, m_ivld);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    cyc(1, 0, 0, 0, '0, 4'b0, 4'b0);
    cyc(0, 1, 1, 2'd0, '1, 4'b0, 4'b0);
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (iadr !== {AW{1'b1}} || npc !== '0 || hart !== 2'd0 || ivld !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ones: iadr=%h npc=%h hart=%0d ivld=%b want 3fffffff 0 0 1", iadr, npc, hart, ivld);
    end
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (iadr !== '0 || npc !== AW'(1)) begin
      errors++;
      $display("FAIL wrap_zero: iadr=%h npc=%h want 0 1", iadr, npc);
    end
    cyc(0, 1, 0, 0, '0, 4'b1110, 4'b0);
    cyc(1, 1, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (ivld !== 1'b0 || active !== 4'b0001 || iadr !== '0) begin
      errors++;
      $display("FAIL midstream_reset: ivld=%b active=%b iadr=%h want 0 0001 0", ivld, active, iadr);
    end
    cyc(0, 1, 0, 0, '0, 4'b0, 4'b0);
    checks++;
    if (iadr !== RSTV || hart !== 2'd0 || ivld !== 1'b1) begin
      errors++;
      $display("FAIL restart: iadr=%h hart=%0d ivld=%b want %h 0 1", iadr, hart, ivld, RSTV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
          2'($urandom_range(0, 3)), AW'($urandom()),
          4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
          4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
      checks++;
      if (iadr !== m_iadr || hart !== m_hart || ivld !== m_ivld || active !== m_act ||
          pc !== {m_iadr, m_hart} || npc !== m_iadr + AW'(1)) begin
        errors++;
        $display("FAIL random[%0d]: iadr=%h hart=%0d ivld=%b act=%b pc=%h npc=%h want %h %0d %b %b",
                 i, iadr, hart, ivld, active, pc, npc, m_iadr, m_hart, m_ivld, m_act);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; bra = 1'b0; bhart = 2'd0; alu = '0; run_set = '0; run_clr = '0;
    @(negedge clk);
    test_reset();
    test_single_hart();
    test_round_robin();
    test_branch();
    test_set_clr();
    test_ena_hold();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
